// File: rtl/logic_gate_sequencer_pkg.sv
// Shared types and golden values for the logic_gates self-test sequencer.
// Bit g of every gate word is the gate selected by the G_* constant with value g.
package logic_gate_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE
  } state_t;

  localparam int G_AND  = 0;
  localparam int G_OR   = 1;
  localparam int G_NAND = 2;
  localparam int G_NOR  = 3;
  localparam int G_NOT  = 4;
  localparam int G_XOR  = 5;
  localparam int G_XNOR = 6;

  localparam logic [6:0] EXP_00 = 7'h5C;
  localparam logic [6:0] EXP_01 = 7'h36;
  localparam logic [6:0] EXP_10 = 7'h26;
  localparam logic [6:0] EXP_11 = 7'h43;

  // idx is the stimulus vector {a,b}
  function automatic logic [6:0] exp_vec(input logic [1:0] idx);
    logic [6:0] word;
    word = EXP_00;
    case (idx)
      2'd1:    word = EXP_01;
      2'd2:    word = EXP_10;
      2'd3:    word = EXP_11;
      default: word = EXP_00;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/logic_gate_sequencer_if.sv
// Control, stimulus and result signals between the self-test sequencer and its user.
interface logic_gate_sequencer_if;

  logic       start;
  logic       abort;
  logic [6:0] gate_in;
  logic       a_out;
  logic       b_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_vec;
  logic [6:0] err_gates;

  modport master (
    output start, abort, gate_in,
    input  a_out, b_out, busy, done, pass, err_vec, err_gates
  );

  modport slave (
    input  start, abort, gate_in,
    output a_out, b_out, busy, done, pass, err_vec, err_gates
  );

endinterface

// File: rtl/logic_gate_sequencer_checker.sv
// Combinational compare of sampled gate outputs against the golden word for vector idx.
module logic_gate_checker
  import logic_gate_pkg::*;
#(
  parameter logic [6:0] GATE_MASK = 7'h7F
) (
  input  logic [6:0] gate_in,
  input  logic [1:0] idx,
  output logic [6:0] mism
);

  assign mism = (gate_in ^ exp_vec(idx)) & GATE_MASK;

endmodule

// File: rtl/logic_gate_sequencer.sv
// BIST sequencer: sweeps {a,b} through 00..11, samples the gate block after a settle
// delay and keeps sticky per-vector / per-gate mismatch flags plus a pass verdict.
module logic_gate_sequencer
  import logic_gate_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [6:0] GATE_MASK     = 7'h7F
) (
  input  logic                   clk,
  input  logic                   rst_n,
  logic_gate_sequencer_if.slave  bus
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] idx;
  logic [7:0] settle_cnt;
  logic [6:0] mism;
  logic       done_q;
  logic       pass_q;
  logic [3:0] err_vec_q;
  logic [6:0] err_gates_q;
  logic       busy_w;
  logic       accept;
  logic       settled;

  // abort has priority over start, so a simultaneous pair never launches a sweep
  assign accept  = (state == IDLE) && bus.start && !bus.abort;
  assign settled = (settle_cnt == SETTLE_LAST);

  logic_gate_checker #(.GATE_MASK(GATE_MASK)) u_checker (
    .gate_in (bus.gate_in),
    .idx     (idx),
    .mism    (mism)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETTLE;
      SETTLE:  if (bus.abort) state_nxt = IDLE;
               else if (settled) state_nxt = SAMPLE;
      SAMPLE:  if (bus.abort || idx == 2'd3) state_nxt = IDLE;
               else state_nxt = SETTLE;
      default: state_nxt = IDLE;
    endcase
  end

  // An aborted sample is discarded: flags keep only fully sampled vectors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= 2'd0;
      settle_cnt  <= 8'd0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_vec_q   <= 4'd0;
      err_gates_q <= 7'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            idx         <= 2'd0;
            settle_cnt  <= 8'd0;
            pass_q      <= 1'b0;
            err_vec_q   <= 4'd0;
            err_gates_q <= 7'd0;
          end
        end
        SETTLE: begin
          if (bus.abort) begin
            idx    <= 2'd0;
            pass_q <= 1'b0;
          end else if (!settled) begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        SAMPLE: begin
          if (bus.abort) begin
            idx    <= 2'd0;
            pass_q <= 1'b0;
          end else begin
            err_gates_q <= err_gates_q | mism;
            if (mism != 7'd0) err_vec_q[idx] <= 1'b1;
            settle_cnt <= 8'd0;
            if (idx == 2'd3) begin
              idx    <= 2'd0;
              done_q <= 1'b1;
              pass_q <= ((err_gates_q | mism) == 7'd0);
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        default: idx <= 2'd0;
      endcase
    end
  end

  // Stimulus follows idx only while a sweep is running, so it drops to 00 with busy
  always_comb begin
    busy_w    = (state != IDLE);
    bus.busy  = busy_w;
    bus.a_out = busy_w & idx[1];
    bus.b_out = busy_w & idx[0];
  end

  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_vec   = err_vec_q;
  assign bus.err_gates = err_gates_q;

endmodule
